// File: rtl/axi4_lite_register_file.sv
// AXI4-Lite slave over 2**CLOG2_W registers: writes drive register_out, reads return register_in.
// Define AXI4_LITE_REGISTER_FILE_SLVERR_EN to answer SLVERR above the map instead of aliasing.
module axi4_lite_register_file #(
  parameter int A       = 16,
  parameter int N       = 4,
  parameter int CLOG2_W = 4,
  localparam int W      = 2**CLOG2_W,
  localparam int DW     = 8*N
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [A-1:0]          awaddr,
  input  logic                  awvalid,
  output logic                  awready,
  input  logic [DW-1:0]         wdata,
  input  logic [N-1:0]          wstrb,
  input  logic                  wvalid,
  output logic                  wready,
  output logic [1:0]            bresp,
  output logic                  bvalid,
  input  logic                  bready,
  input  logic [A-1:0]          araddr,
  input  logic                  arvalid,
  output logic                  arready,
  output logic [DW-1:0]         rdata,
  output logic [1:0]            rresp,
  output logic                  rvalid,
  input  logic                  rready,
  output logic [W-1:0][DW-1:0]  register_out,
  input  logic [W-1:0][DW-1:0]  register_in
);

  localparam int OB = $clog2(N);
  localparam int IB = CLOG2_W + OB;
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

`ifdef AXI4_LITE_REGISTER_FILE_SLVERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic               booted;
  logic               aw_done;
  logic               w_done;
  logic [CLOG2_W-1:0] aw_idx;
  logic               aw_err;
  logic [DW-1:0]      wdata_q;
  logic [N-1:0]       wstrb_q;
  logic [CLOG2_W-1:0] ar_idx;
  logic               ar_err;
  logic               aw_err_in;
  logic               unused;

  assign ar_idx    = araddr[IB-1:OB];
  assign ar_err    = ERR_EN && ((araddr >> IB) != '0);
  assign aw_err_in = ERR_EN && ((awaddr >> IB) != '0);
  assign unused    = ^{awaddr, araddr};

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      booted       <= 1'b0;
      awready      <= 1'b0;
      wready       <= 1'b0;
      arready      <= 1'b0;
      aw_done      <= 1'b0;
      w_done       <= 1'b0;
      aw_idx       <= '0;
      aw_err       <= 1'b0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      bvalid       <= 1'b0;
      bresp        <= OKAY;
      rvalid       <= 1'b0;
      rresp        <= OKAY;
      rdata        <= '0;
      register_out <= '0;
    end else begin
      booted <= 1'b1;
      if (!booted) begin
        awready <= 1'b1;
        wready  <= 1'b1;
        arready <= 1'b1;
      end
      if (awvalid && awready) begin
        awready <= 1'b0;
        aw_done <= 1'b1;
        aw_idx  <= awaddr[IB-1:OB];
        aw_err  <= aw_err_in;
      end
      if (wvalid && wready) begin
        wready  <= 1'b0;
        w_done  <= 1'b1;
        wdata_q <= wdata;
        wstrb_q <= wstrb;
      end
      // readys stay low until B completes, so this fires once per write
      if (aw_done && w_done) begin
        aw_done <= 1'b0;
        w_done  <= 1'b0;
        bvalid  <= 1'b1;
        if (aw_err) begin
          bresp <= SLVERR;
        end else begin
          bresp <= OKAY;
          for (int i = 0; i < N; i++) begin
            if (wstrb_q[i]) begin
              register_out[aw_idx][8*i +: 8] <= wdata_q[8*i +: 8];
            end
          end
        end
      end
      if (bvalid && bready) begin
        bvalid  <= 1'b0;
        awready <= 1'b1;
        wready  <= 1'b1;
      end
      if (arvalid && arready) begin
        arready <= 1'b0;
        rvalid  <= 1'b1;
        if (ar_err) begin
          rdata <= '0;
          rresp <= SLVERR;
        end else begin
          rdata <= register_in[ar_idx];
          rresp <= OKAY;
        end
      end
      if (rvalid && rready) begin
        rvalid  <= 1'b0;
        arready <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_axi4_lite_register_file.sv
// Randomised bench for axi4_lite_register_file against a word-array model.
// Loopback on registers 0..14, constant 0xB19B00B5 on register 15.
module tb_axi4_lite_register_file;

  localparam int A = 16;
  localparam int N = 4;
  localparam int CLOG2_W = 4;
  localparam int W = 16;
  localparam int TMO = 50;

  logic              aclk = 1'b0;
  logic              aresetn = 1'b0;
  logic [A-1:0]      awaddr = '0;
  logic              awvalid = 1'b0;
  logic              awready;
  logic [31:0]       wdata = '0;
  logic [3:0]        wstrb = '0;
  logic              wvalid = 1'b0;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready = 1'b0;
  logic [A-1:0]      araddr = '0;
  logic              arvalid = 1'b0;
  logic              arready;
  logic [31:0]       rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready = 1'b0;
  logic [W-1:0][31:0] register_out;
  logic [W-1:0][31:0] register_in;

  always_comb begin
    register_in     = register_out;
    register_in[15] = 32'hB19B00B5;
  end

  axi4_lite_register_file #(.A(A), .N(N), .CLOG2_W(CLOG2_W)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .register_out(register_out), .register_in(register_in)
  );

  always #5 aclk = ~aclk;

  logic [31:0] model [W];
  bit          wr_busy = 1'b1;
  bit          mon_en = 1'b0;
  int          n_checks = 0;
  int          n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic tmo(input string nm);
    n_checks++;
    n_fail++;
    $display("FAIL %s: no handshake within %0d cycles", nm, TMO);
  endtask

  function automatic bit above_map(input logic [A-1:0] a);
`ifdef AXI4_LITE_REGISTER_FILE_SLVERR_EN
    return a >= 16'h0040;
`else
    return a > 16'hFFFF;
`endif
  endfunction

  function automatic logic [33:0] ref_read(input logic [A-1:0] a);
    int i;
    i = int'(a[5:2]);
    if (above_map(a)) return {2'b10, 32'h0};
    if (i == 15) return {2'b00, 32'hB19B00B5};
    return {2'b00, model[i]};
  endfunction

  task automatic ref_write(input logic [A-1:0] a, input logic [31:0] d,
                           input logic [3:0] s, output logic [1:0] r);
    int i;
    i = int'(a[5:2]);
    r = 2'b00;
    if (above_map(a)) begin
      r = 2'b10;
    end else begin
      for (int k = 0; k < 4; k++)
        if (s[k]) model[i][8*k +: 8] = d[8*k +: 8];
    end
  endtask

  // every settled cycle the register array must equal the model
  always @(negedge aclk) begin
    if (mon_en && !wr_busy) begin
      int bad;
      bad = -1;
      for (int i = 0; i < W; i++)
        if (bad < 0 && register_out[i] !== model[i]) bad = i;
      n_checks++;
      if (bad >= 0) begin
        n_fail++;
        $display("FAIL register_out[%0d]: got %h, expected %h",
                 bad, register_out[bad], model[bad]);
      end
    end
  end

  task automatic axi_write(input logic [A-1:0] a, input logic [31:0] d,
                           input logic [3:0] s, input int aw_dly,
                           input int w_dly, input int b_dly,
                           output logic [1:0] got);
    logic [1:0] er;
    int t;
    wr_busy = 1'b1;
    fork
      begin
        int ta;
        repeat (aw_dly) @(posedge aclk);
        #1 awaddr = a; awvalid = 1'b1;
        ta = 0;
        @(negedge aclk);
        while (!awready && ta < TMO) begin @(negedge aclk); ta++; end
        if (!awready) tmo("aw");
        @(posedge aclk); #1 awvalid = 1'b0;
      end
      begin
        int tw;
        repeat (w_dly) @(posedge aclk);
        #1 wdata = d; wstrb = s; wvalid = 1'b1;
        tw = 0;
        @(negedge aclk);
        while (!wready && tw < TMO) begin @(negedge aclk); tw++; end
        if (!wready) tmo("w");
        @(posedge aclk); #1 wvalid = 1'b0;
      end
    join
    t = 0;
    @(negedge aclk);
    while (!bvalid && t < TMO) begin @(negedge aclk); t++; end
    if (!bvalid) tmo("b");
    got = bresp;
    repeat (b_dly) begin
      @(negedge aclk);
      chk("b_hold", {bvalid, bresp}, {1'b1, got});
    end
    bready = 1'b1;
    @(posedge aclk); #1 bready = 1'b0;
    ref_write(a, d, s, er);
    chk("bresp", got, er);
    wr_busy = 1'b0;
  endtask

  task automatic axi_read(input logic [A-1:0] a, input int r_dly,
                          output logic [31:0] got, output logic [1:0] gresp);
    logic [33:0] e;
    int t;
    araddr = a; arvalid = 1'b1;
    t = 0;
    @(negedge aclk);
    while (!arready && t < TMO) begin @(negedge aclk); t++; end
    if (!arready) tmo("ar");
    e = ref_read(a);
    @(posedge aclk); #1 arvalid = 1'b0;
    t = 0;
    @(negedge aclk);
    while (!rvalid && t < TMO) begin @(negedge aclk); t++; end
    if (!rvalid) tmo("r");
    got = rdata;
    gresp = rresp;
    repeat (r_dly) begin
      @(negedge aclk);
      chk("r_hold", {rvalid, rresp, rdata}, {1'b1, gresp, got});
    end
    chk("rdata", got, e[31:0]);
    chk("rresp", gresp, e[33:32]);
    rready = 1'b1;
    @(posedge aclk); #1 rready = 1'b0;
  endtask

  logic [31:0] rd;
  logic [1:0]  rs;
  logic [1:0]  bs;

  initial begin
    for (int i = 0; i < W; i++) model[i] = '0;
    repeat (3) @(posedge aclk);
    mon_en = 1'b1;
    wr_busy = 1'b0;
    @(negedge aclk);
    chk("reset_outs", {awready, wready, arready, bvalid, rvalid, bresp, rresp, rdata},
        '0);
    @(posedge aclk); #1 aresetn = 1'b1;
    @(negedge aclk);
    chk("readys_low_at_release", {awready, wready, arready}, 3'b000);
    @(posedge aclk);
    @(negedge aclk);
    chk("readys_up", {awready, wready, arready}, 3'b111);
    @(posedge aclk); #1;

    axi_read(16'h003C, 0, rd, rs);
    chk("lit_rd_3c", {rs, rd}, {2'b00, 32'hB19B00B5});
    axi_read(16'h0004, 1, rd, rs);
    chk("lit_rd_04_reset", rd, 32'h0);
    axi_write(16'h0004, 32'hABBABEEF, 4'hF, 0, 0, 0, bs);
    chk("lit_bresp", bs, 2'b00);
    axi_read(16'h0004, 0, rd, rs);
    chk("lit_rd_04_a", rd, 32'hABBABEEF);
    axi_read(16'h0004, 2, rd, rs);
    chk("lit_rd_04_b", rd, 32'hABBABEEF);
    axi_read(16'h003C, 0, rd, rs);
    chk("lit_rd_3c_again", rd, 32'hB19B00B5);
    axi_read(16'h0004, 0, rd, rs);
    chk("lit_rd_04_c", rd, 32'hABBABEEF);
    axi_write(16'h0004, 32'hABCD1234, 4'hF, 0, 0, 0, bs);
    axi_read(16'h0004, 0, rd, rs);
    chk("lit_rd_04_d", rd, 32'hABCD1234);
    axi_write(16'h0008, 32'h11223344, 4'h3, 0, 0, 0, bs);
    axi_read(16'h0008, 0, rd, rs);
    chk("lit_rd_08_strb", rd, 32'h00003344);
    axi_write(16'h000C, 32'hCAFEF00D, 4'hF, 0, 2, 3, bs);
    axi_read(16'h000C, 0, rd, rs);
    chk("lit_aw_first", rd, 32'hCAFEF00D);
    axi_write(16'h000C, 32'h12345678, 4'h0, 0, 0, 0, bs);
    axi_read(16'h000C, 0, rd, rs);
    chk("lit_strb0", {rs, rd}, {2'b00, 32'hCAFEF00D});
    axi_write(16'h0010, 32'h5A5A0001, 4'hF, 3, 0, 1, bs);
    axi_read(16'h0010, 0, rd, rs);
    chk("lit_w_first", rd, 32'h5A5A0001);

    fork
      axi_write(16'h0014, 32'h0BADBEEF, 4'hF, 0, 0, 1, bs);
      begin
        logic [31:0] d2;
        logic [1:0]  r2;
        axi_read(16'h000C, 0, d2, r2);
        chk("lit_concurrent_rd", d2, 32'hCAFEF00D);
      end
    join
    @(posedge aclk); #1;

`ifdef AXI4_LITE_REGISTER_FILE_SLVERR_EN
    axi_read(16'h0040, 0, rd, rs);
    chk("lit_rd_40_err", {rs, rd}, {2'b10, 32'h0});
    axi_write(16'h0044, 32'hFFFFFFFF, 4'hF, 0, 0, 0, bs);
    chk("lit_wr_44_err", bs, 2'b10);
`else
    axi_read(16'h0044, 0, rd, rs);
    chk("lit_rd_44_alias", {rs, rd}, {2'b00, 32'hABCD1234});
`endif

    for (int n = 0; n < 120; n++) begin
      logic [A-1:0] a;
      a = A'($urandom_range(0, 31) * 4);
      if ($urandom_range(0, 1) == 1)
        axi_write(a, $urandom, 4'($urandom_range(0, 15)),
                  $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 3), bs);
      else
        axi_read(a, $urandom_range(0, 3), rd, rs);
    end

    // reset lands between the AW/W handshake and the register update
    wr_busy = 1'b1;
    awaddr = 16'h0018; awvalid = 1'b1;
    wdata = 32'hDEADDEAD; wstrb = 4'hF; wvalid = 1'b1;
    @(negedge aclk);
    chk("mid_readys", {awready, wready}, 2'b11);
    @(posedge aclk); #1;
    awvalid = 1'b0; wvalid = 1'b0; aresetn = 1'b0;
    for (int i = 0; i < W; i++) model[i] = '0;
    @(posedge aclk); #1;
    wr_busy = 1'b0;
    @(negedge aclk);
    chk("mid_reset_b", {bvalid, rvalid}, 2'b00);
    @(posedge aclk); #1 aresetn = 1'b1;
    repeat (2) @(posedge aclk);
    #1;
    axi_read(16'h0018, 0, rd, rs);
    chk("lit_mid_reset_rd", rd, 32'h0);

    @(negedge aclk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
